// File: rtl/tdm_pkg.sv
// tdm_pkg: shared state enum and slot constants for the 4-slot TDM demultiplexer
package tdm_pkg;
  typedef enum logic {HUNT, LOCKED} state_e;
  localparam int SLOT_W = 2;
  localparam logic [SLOT_W-1:0] SLOT_A = 2'd0;
  localparam logic [SLOT_W-1:0] SLOT_B = 2'd1;
  localparam logic [SLOT_W-1:0] SLOT_C = 2'd2;
  localparam logic [SLOT_W-1:0] SLOT_D = 2'd3;
endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: 2-bit slot counter with load-zero, increment and natural wrap
// Ports: clk, rst (sync, active-high); clr_i loads SLOT_A; inc_i advances;
//        slot_o is the last accepted slot, nxt_o the slot expected next.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [SLOT_W-1:0] slot_o,
  output logic [SLOT_W-1:0] nxt_o
);
  logic [SLOT_W-1:0] slot_q, slot_d;
  assign nxt_o  = slot_q + SLOT_W'(1);
  assign slot_d = clr_i ? SLOT_A : inc_i ? nxt_o : slot_q;
  assign slot_o = slot_q;
  always_ff @(posedge clk)
    if (rst) slot_q <= SLOT_A;
    else     slot_q <= slot_d;
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: recovers four 1-bit channels from a framed serial TDM stream
// Ports: CLK, RST (sync, active-high); Y serial data, EN sample strobe,
//        FSYNC frame sync on slot A; A..D recovered channels, {S1,S0} last
//        accepted slot, VALID frame-update pulse, ERR sync-violation pulse,
//        LOCK high while locked to the frame.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter bit SYNC_CHECK = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic Y,
  input  logic EN,
  input  logic FSYNC,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic S1,
  output logic S0,
  output logic VALID,
  output logic ERR,
  output logic LOCK
);
  state_e state_q, state_d;
  logic [2:0] sh_q, sh_d;
  logic [3:0] out_q, out_d;
  logic valid_q, valid_d, err_q, err_d, clr, inc;
  logic [SLOT_W-1:0] slot, nxt;
  tdm_slot_ctr u_ctr (
    .clk   (CLK),
    .rst   (RST),
    .clr_i (clr),
    .inc_i (inc),
    .slot_o(slot),
    .nxt_o (nxt)
  );
  // out_q/sh_q bit 0 is channel A; the slot-3 sample bypasses the shadows into D
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    out_d   = out_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    clr     = 1'b0;
    inc     = 1'b0;
    if (EN) begin
      if (state_q == HUNT) begin
        if (FSYNC) begin
          clr     = 1'b1;
          sh_d[0] = Y;
          state_d = LOCKED;
        end
      end else if (nxt == SLOT_A && !FSYNC && SYNC_CHECK) begin
        err_d   = 1'b1;
        state_d = HUNT;
      end else if (FSYNC || nxt == SLOT_A) begin
        // FSYNC inside a frame restarts it: this sample becomes slot A
        err_d   = nxt != SLOT_A;
        clr     = 1'b1;
        sh_d[0] = Y;
      end else if (nxt == SLOT_D) begin
        inc     = 1'b1;
        out_d   = {Y, sh_q};
        valid_d = 1'b1;
      end else begin
        inc       = 1'b1;
        sh_d[nxt] = Y;
      end
    end
  end
  always_ff @(posedge CLK)
    if (RST) begin
      state_q <= HUNT;
      sh_q    <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  assign {D, C, B, A} = out_q;
  assign {S1, S0}     = slot;
  assign VALID        = valid_q;
  assign ERR          = err_q;
  assign LOCK         = state_q == LOCKED;
endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 The block SHALL have parameter SYNC_CHECK, default 1, meaning: when 1, a missing FSYNC at an expected slot 0 is flagged and drops lock.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-003 The block SHALL have port RST, input, 1 bit: the reset, which is synchronous and active-high.
REQ-004 The block SHALL have port Y, input, 1 bit: the serial TDM data stream (mux output carrying slots A,B,C,D in order).
REQ-005 The block SHALL have port EN, input, 1 bit: the sample strobe; Y and FSYNC are only meaningful in cycles where EN=1.
REQ-006 The block SHALL have port FSYNC, input, 1 bit: frame sync, high together with EN on the slot-0 (A) sample.
REQ-007 The block SHALL have ports A, B, C, D, outputs, 1 bit each: the recovered channel values, registered and held between frames.
REQ-008 The block SHALL have ports S1, S0, outputs, 1 bit each: the slot index (MSB, LSB) of the last accepted sample.
REQ-009 The block SHALL have port VALID, output, 1 bit: a one-cycle pulse when A..D are updated with a complete frame.
REQ-010 The block SHALL have port ERR, output, 1 bit: a one-cycle pulse on a sync violation.
REQ-011 The block SHALL have port LOCK, output, 1 bit: high while in state LOCKED.

Function
REQ-012 The block SHALL implement an FSM with two states: HUNT and LOCKED.
REQ-013 In HUNT, EN=1 with FSYNC=0 SHALL discard the sample with no output change.
REQ-014 In HUNT, EN=1 with FSYNC=1 SHALL capture Y as slot 0, set {S1,S0}=00, and go to LOCKED.
REQ-015 In LOCKED, each EN=1 SHALL advance the slot 0->1->2->3->0, capture Y into the shadow register for that slot, and update {S1,S0}.
REQ-016 Shadow registers SHALL be used for slots 0..2; the slot-3 sample SHALL go directly to D.
REQ-017 On the edge that accepts the slot-3 sample, A,B,C SHALL load from the shadow registers and D from Y, with VALID=1 for exactly the following cycle (latency 1 cycle from the slot-3 sample).
REQ-018 A,B,C,D SHALL hold their value until the next complete frame.
REQ-019 In LOCKED, FSYNC=1 on an expected slot 0 SHALL be normal operation.
REQ-020 In LOCKED, FSYNC=1 on an expected slot 1..3 SHALL pulse ERR, discard the partial frame (no VALID), and restart at slot 0 with this sample captured.
REQ-021 In LOCKED with SYNC_CHECK=1, FSYNC=0 on an expected slot 0 SHALL pulse ERR, discard the sample, and return to HUNT.
REQ-022 With SYNC_CHECK=0, the condition in REQ-021 SHALL be accepted as slot 0.
REQ-023 Cycles with EN=0 SHALL change nothing except clearing VALID and ERR; FSYNC SHALL be ignored when EN=0.
REQ-024 VALID and ERR SHALL never be high in the same cycle.

Reset
REQ-025 RST=1 at a rising edge SHALL force HUNT, A=B=C=D=0, S1=S0=0, VALID=ERR=LOCK=0, and clear the shadow registers.
REQ-026 RST SHALL dominate EN and FSYNC.
REQ-027 A reset mid-frame SHALL discard the partial frame with no VALID.

Structure
REQ-028 Package tdm_pkg SHALL hold the state enum (HUNT, LOCKED), SLOT_W=2, and the slot constants SLOT_A..SLOT_D.
REQ-029 Sub-module tdm_slot_ctr SHALL contain the 2-bit slot counter with load-zero, increment, and wrap.
REQ-030 The FSM and data registers SHALL reside in tdm_demux4.

Verification
REQ-031 Reset, then send frame A=1,B=0,C=1,D=0 with FSYNC on A -> A..D=1,0,1,0, VALID for 1 cycle after the D sample, LOCK=1.
REQ-032 Send a second frame 0,1,0,1 with gaps of EN=0 between samples -> outputs hold 1,0,1,0 until the D sample, then show 0,1,0,1 with one VALID.
REQ-033 Assert FSYNC on the C sample mid-frame -> ERR pulse, no VALID, {S1,S0}=00, and the next three samples complete the frame.
REQ-034 With SYNC_CHECK=1, omit FSYNC at the frame start -> ERR pulse, LOCK=0, and later samples are ignored until FSYNC.
REQ-035 Assert RST after the B sample -> all outputs 0 on the next cycle, HUNT, and no VALID.
REQ-036 Drive FSYNC=1 with EN=0 in HUNT -> LOCK stays 0.
